// File: rtl/hmc6502_pkg.sv
// Shared constants for the hmc-6502 execution core: ALU op codes,
// register-file indices and status-flag bit positions.
package hmc6502_pkg;

    typedef enum logic [3:0] {
        ALU_OR    = 4'd0,
        ALU_AND   = 4'd1,
        ALU_EOR   = 4'd2,
        ALU_ADC   = 4'd3,
        ALU_SBC   = 4'd4,
        ALU_ASL   = 4'd5,
        ALU_LSR   = 4'd6,
        ALU_ROL   = 4'd7,
        ALU_ROR   = 4'd8,
        ALU_PASSA = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_INC   = 4'd11,
        ALU_DEC   = 4'd12,
        ALU_CMP   = 4'd13,
        ALU_BIT   = 4'd14,
        ALU_ADD   = 4'd15
    } alu_op_e;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_X = 2'd1;
    localparam logic [1:0] REG_Y = 2'd2;
    localparam logic [1:0] REG_S = 2'd3;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/hmc6502_alu.sv
// Purely combinational 8-bit 6502 ALU with binary and decimal (BCD)
// add/subtract. Flags come out as {N,V,0,0,0,0,Z,C}.
module hmc6502_alu
    import hmc6502_pkg::*;
(
    input  alu_op_e      op,
    input  logic [7:0]   a,
    input  logic [7:0]   b,
    input  logic         ci,
    input  logic         bcd,
    output logic [7:0]   result,
    output logic [7:0]   flags
);

    logic [7:0] bb;       // b, inverted for the subtracting ops
    logic       cin;      // CMP always subtracts with carry set
    logic [8:0] sum9;
    logic [4:0] lo;
    logic [4:0] hi;
    logic       half;
    logic [7:0] dec_r;
    logic       dec_c;
    logic [7:0] r;
    logic       c;
    logic       v;

    // Shared binary adder: a + b (or ~b) + carry-in
    always_comb begin
        bb   = (op == ALU_SBC || op == ALU_CMP) ? ~b : b;
        cin  = (op == ALU_CMP) ? 1'b1 : ci;
        sum9 = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
    end

    // Decimal path: nibble-wise add/subtract with +6/-6 correction.
    // Non-decimal digits are simply run through the same correction.
    always_comb begin
        lo    = '0;
        hi    = '0;
        half  = 1'b0;
        dec_r = '0;
        dec_c = 1'b0;
        if (op == ALU_SBC) begin
            lo          = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'b0, ci};
            half        = lo[4];
            dec_r[3:0]  = half ? lo[3:0] : lo[3:0] - 4'd6;
            hi          = {1'b0, a[7:4]} + {1'b0, ~b[7:4]} + {4'b0, half};
            dec_c       = hi[4];
            dec_r[7:4]  = dec_c ? hi[3:0] : hi[3:0] - 4'd6;
        end else begin
            lo          = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
            half        = (lo > 5'd9);
            dec_r[3:0]  = lo[3:0] + (half ? 4'd6 : 4'd0);
            hi          = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, half};
            dec_c       = (hi > 5'd9);
            dec_r[7:4]  = hi[3:0] + (dec_c ? 4'd6 : 4'd0);
        end
    end

    // Operation select and flag assembly
    always_comb begin
        r = '0;
        c = ci;
        v = 1'b0;
        case (op)
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_EOR:   r = a ^ b;
            ALU_ADC,
            ALU_SBC:   {c, r} = bcd ? {dec_c, dec_r} : sum9;
            ALU_CMP,
            ALU_ADD:   {c, r} = sum9;
            ALU_ASL:   begin r = {a[6:0], 1'b0}; c = a[7]; end
            ALU_LSR:   begin r = {1'b0, a[7:1]}; c = a[0]; end
            ALU_ROL:   begin r = {a[6:0], ci};   c = a[7]; end
            ALU_ROR:   begin r = {ci, a[7:1]};   c = a[0]; end
            ALU_PASSA: r = a;
            ALU_PASSB: r = b;
            ALU_INC:   r = a + 8'd1;
            ALU_DEC:   r = a - 8'd1;
            ALU_BIT:   r = a & b;
            default:   r = '0;
        endcase

        // Overflow is judged on the final (possibly decimal-adjusted) result
        if (op == ALU_ADC || op == ALU_SBC || op == ALU_CMP || op == ALU_ADD)
            v = (a[7] == bb[7]) && (r[7] != a[7]);
        else if (op == ALU_BIT)
            v = b[6];

        result         = r;
        flags          = '0;
        flags[FLAG_N]  = (op == ALU_BIT) ? b[7] : r[7];
        flags[FLAG_V]  = v;
        flags[FLAG_Z]  = (r == 8'h00);
        flags[FLAG_C]  = c;
    end

endmodule

// File: rtl/alu_regfile_core.sv
// hmc-6502 execution core: 4x8 register file (A,X,Y,S), operand and
// carry-in muxes, the ALU, and the registered result/flag stage.
module alu_regfile_core
    import hmc6502_pkg::*;
(
    input  logic         ph2,
    input  logic         reset,
    input  logic [7:0]   data_in,
    input  logic [7:0]   constant,
    input  logic [1:0]   a_sel,
    input  logic         b_sel,
    input  logic [7:0]   b_ext,
    input  logic [1:0]   reg_read_addr_a,
    input  logic [1:0]   reg_read_addr_b,
    input  logic [1:0]   reg_write_addr,
    input  logic         reg_write_en,
    input  logic [3:0]   alu_op,
    input  logic [1:0]   carry_sel,
    input  logic         p_c,
    input  logic         bcd,
    input  logic         c_temp_en,
    output logic [7:0]   r_q,
    output logic [7:0]   flags_q,
    output logic [7:0]   reg_a_data,
    output logic [7:0]   reg_b_data
);

    logic [3:0][7:0] regs;
    logic            c_temp;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic            ci;
    logic [7:0]      alu_r;
    logic [7:0]      alu_f;

    assign reg_a_data = regs[reg_read_addr_a];
    assign reg_b_data = regs[reg_read_addr_b];

    // Operand and carry-in selection
    always_comb begin
        case (a_sel)
            2'd0:    op_a = reg_a_data;
            2'd1:    op_a = data_in;
            2'd2:    op_a = constant;
            default: op_a = 8'h00;
        endcase
        op_b = b_sel ? b_ext : reg_b_data;
        case (carry_sel)
            2'd0:    ci = p_c;
            2'd1:    ci = c_temp;
            2'd2:    ci = 1'b0;
            default: ci = 1'b1;
        endcase
    end

    hmc6502_alu u_alu (
        .op     (alu_op_e'(alu_op)),
        .a      (op_a),
        .b      (op_b),
        .ci     (ci),
        .bcd    (bcd),
        .result (alu_r),
        .flags  (alu_f)
    );

    // Register file: writeback takes the already-registered result
    always_ff @(posedge ph2) begin
        if (reset)
            regs <= '0;
        else if (reg_write_en)
            regs[reg_write_addr] <= r_q;
    end

    // Result/flag stage plus saved carry for multi-byte address chains
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_q     <= '0;
            flags_q <= '0;
            c_temp  <= 1'b0;
        end else begin
            r_q     <= alu_r;
            flags_q <= alu_f;
            if (c_temp_en)
                c_temp <= flags_q[FLAG_C];
        end
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
// Self-checking bench for alu_regfile_core: an integer-arithmetic model
// compared every cycle, plus hand-computed directed expectations.
module tb_alu_regfile_core;
    import hmc6502_pkg::*;

    logic       ph2 = 1'b0;
    logic       reset;
    logic [7:0] data_in, constant, b_ext;
    logic [1:0] a_sel, carry_sel;
    logic       b_sel, reg_write_en, p_c, bcd, c_temp_en;
    logic [1:0] reg_read_addr_a, reg_read_addr_b, reg_write_addr;
    logic [3:0] alu_op;
    logic [7:0] r_q, flags_q, reg_a_data, reg_b_data;

    int checks = 0;
    int errors = 0;

    alu_regfile_core dut (
        .ph2(ph2), .reset(reset), .data_in(data_in), .constant(constant),
        .a_sel(a_sel), .b_sel(b_sel), .b_ext(b_ext),
        .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
        .reg_write_addr(reg_write_addr), .reg_write_en(reg_write_en),
        .alu_op(alu_op), .carry_sel(carry_sel), .p_c(p_c), .bcd(bcd),
        .c_temp_en(c_temp_en), .r_q(r_q), .flags_q(flags_q),
        .reg_a_data(reg_a_data), .reg_b_data(reg_b_data)
    );

    always #5 ph2 = ~ph2;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int bcd2int(input int x);
        return (x / 16) * 10 + (x % 16);
    endfunction

    function automatic int int2bcd(input int x);
        return (x / 10) * 16 + (x % 10);
    endfunction

    function automatic bit sgn_ovf(input int x, input int y, input int r);
        return ((x >= 128) == (y >= 128)) && ((r >= 128) != (x >= 128));
    endfunction

    // Returns {flags, result}
    function automatic logic [15:0] model_alu(input int op, input int a, input int b,
                                              input bit ci, input bit d);
        int r, s, sa, sb;
        bit c, v, n, z;
        c = ci; v = 1'b0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        n = 1'b0;
        case (op)
            0: r = a | b;
            1: r = a & b;
            2: r = a ^ b;
            3, 15: begin
                if (d && op == 3) begin
                    s = bcd2int(a) + bcd2int(b) + int'(ci);
                    c = (s >= 100);
                    r = int2bcd(s % 100);
                    v = sgn_ovf(a, b, r);
                end else begin
                    s = a + b + int'(ci);
                    c = (s > 255);
                    r = s % 256;
                    s = sa + sb + int'(ci);
                    v = (s > 127) || (s < -128);
                end
            end
            4: begin
                if (d) begin
                    s = bcd2int(a) - bcd2int(b) - (1 - int'(ci));
                    c = (s >= 0);
                    if (s < 0) s += 100;
                    r = int2bcd(s);
                    v = sgn_ovf(a, 255 - b, r);
                end else begin
                    s = a - b - (1 - int'(ci));
                    c = (s >= 0);
                    r = s & 255;
                    s = sa - sb - (1 - int'(ci));
                    v = (s > 127) || (s < -128);
                end
            end
            5:  begin r = (a * 2) & 255;            c = (a >= 128); end
            6:  begin r = a / 2;                    c = (a % 2) == 1; end
            7:  begin r = (a * 2 + int'(ci)) & 255; c = (a >= 128); end
            8:  begin r = a / 2 + 128 * int'(ci);   c = (a % 2) == 1; end
            9:  r = a;
            10: r = b;
            11: r = (a + 1) % 256;
            12: r = (a + 255) % 256;
            13: begin
                s = a - b;
                c = (s >= 0);
                r = s & 255;
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            14: begin r = a & b; v = (b & 64) != 0; end
            default: r = 0;
        endcase
        n = (op == 14) ? (b >= 128) : (r >= 128);
        z = (r == 0);
        return {n, v, 4'b0000, z, c, 8'(r)};
    endfunction

    logic [7:0] m_regs [4];
    logic [7:0] m_r, m_f;
    bit         m_ct;
    bit         m_valid = 1'b0;

    // Model advances on the same edge as the DUT, from the same inputs
    always @(posedge ph2) begin : model
        int ma, mb;
        bit mci;
        logic [15:0] res;
        if (reset === 1'b1) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_r = 8'h00; m_f = 8'h00; m_ct = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (a_sel)
                2'd0:    ma = int'(m_regs[reg_read_addr_a]);
                2'd1:    ma = int'(data_in);
                2'd2:    ma = int'(constant);
                default: ma = 0;
            endcase
            mb = b_sel ? int'(b_ext) : int'(m_regs[reg_read_addr_b]);
            case (carry_sel)
                2'd0:    mci = p_c;
                2'd1:    mci = m_ct;
                2'd2:    mci = 1'b0;
                default: mci = 1'b1;
            endcase
            res = model_alu(int'(alu_op), ma, mb, mci, bcd);
            if (reg_write_en) m_regs[reg_write_addr] = m_r;
            if (c_temp_en)    m_ct = m_f[0];
            m_r = res[7:0];
            m_f = res[15:8];
        end
    end

    // Continuous comparison, mid-cycle
    always @(negedge ph2) begin
        if (m_valid) begin
            check("r_q", r_q, m_r);
            check("flags_q", flags_q, m_f);
            check("reg_a_data", reg_a_data, m_regs[reg_read_addr_a]);
            check("reg_b_data", reg_b_data, m_regs[reg_read_addr_b]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input alu_op_e op, input logic [1:0] asel, input logic [7:0] cst,
                          input logic bsel, input logic [7:0] bx,
                          input logic [1:0] csel, input logic d);
        alu_op = op; a_sel = asel; constant = cst; b_sel = bsel; b_ext = bx;
        carry_sel = csel; bcd = d; reg_write_en = 1'b0; c_temp_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    logic [7:0] tbl_a [2];
    logic [7:0] tbl_b [2];

    initial begin
        reset = 1'b1; data_in = 8'h00; constant = 8'h00; b_ext = 8'h00;
        a_sel = 2'd0; b_sel = 1'b0; carry_sel = 2'd0; p_c = 1'b0; bcd = 1'b0;
        reg_read_addr_a = REG_A; reg_read_addr_b = REG_A; reg_write_addr = REG_A;
        reg_write_en = 1'b0; alu_op = 4'd0; c_temp_en = 1'b0;
        tick();
        reset = 1'b0;
        check("reset r_q", r_q, 8'h00);
        check("reset flags_q", flags_q, 8'h00);
        for (int i = 0; i < 4; i++) begin
            reg_read_addr_a = 2'(i);
            #1;
            check("reset reg", reg_a_data, 8'h00);
        end

        // 7F + 01: signed overflow into negative
        set_op(ALU_ADC, 2'd2, 8'h7F, 1'b1, 8'h01, 2'd2, 1'b0);
        tick();
        check("adc 7f+01 r", r_q, 8'h80);
        check("adc 7f+01 flags", flags_q, 8'hC0);

        // Write r_q to X; old value visible until the edge
        set_op(ALU_PASSA, 2'd3, 8'h00, 1'b1, 8'h00, 2'd2, 1'b0);
        reg_write_en = 1'b1; reg_write_addr = REG_X; reg_read_addr_a = REG_X;
        #1;
        check("X before write", reg_a_data, 8'h00);
        tick();
        reg_write_en = 1'b0;
        check("X after write", reg_a_data, 8'h80);

        // Decimal add and subtract
        set_op(ALU_ADC, 2'd2, 8'h58, 1'b1, 8'h46, 2'd3, 1'b1);
        tick();
        check("bcd 58+46+1 r", r_q, 8'h05);
        check("bcd 58+46+1 flags", flags_q, 8'h01);
        set_op(ALU_SBC, 2'd2, 8'h40, 1'b1, 8'h01, 2'd3, 1'b1);
        tick();
        check("bcd 40-01 r", r_q, 8'h39);
        check("bcd 40-01 flags", flags_q, 8'h01);
        set_op(ALU_ADC, 2'd2, 8'h99, 1'b1, 8'h01, 2'd2, 1'b1);
        tick();
        check("bcd 99+01 r", r_q, 8'h00);
        check("bcd 99+01 flags", flags_q, 8'h03);
        set_op(ALU_SBC, 2'd2, 8'h00, 1'b1, 8'h01, 2'd3, 1'b1);
        tick();
        check("bcd 00-01 r", r_q, 8'h99);
        check("bcd 00-01 flags", flags_q, 8'h80);
        set_op(ALU_ADD, 2'd2, 8'h09, 1'b1, 8'h01, 2'd2, 1'b1);
        tick();
        check("add ignores bcd", r_q, 8'h0A);

        // Carry chain through c_temp
        set_op(ALU_ADD, 2'd2, 8'hFF, 1'b1, 8'h01, 2'd2, 1'b0);
        tick();
        check("add ff+01 r", r_q, 8'h00);
        check("add ff+01 flags", flags_q, 8'h03);
        set_op(ALU_PASSA, 2'd3, 8'h00, 1'b1, 8'h00, 2'd2, 1'b0);
        c_temp_en = 1'b1;
        tick();
        set_op(ALU_ADD, 2'd2, 8'h12, 1'b1, 8'h00, 2'd1, 1'b0);
        tick();
        check("carry chain r", r_q, 8'h13);

        set_op(ALU_ROR, 2'd2, 8'h01, 1'b1, 8'h00, 2'd3, 1'b0);
        tick();
        check("ror r", r_q, 8'h80);
        check("ror flags", flags_q, 8'h81);
        set_op(ALU_BIT, 2'd2, 8'h0F, 1'b1, 8'hC0, 2'd2, 1'b0);
        tick();
        check("bit r", r_q, 8'h00);
        check("bit flags", flags_q, 8'hC2);
        set_op(ALU_DEC, 2'd2, 8'h00, 1'b1, 8'h00, 2'd2, 1'b0);
        tick();
        check("dec 00 r", r_q, 8'hFF);
        check("dec 00 flags", flags_q, 8'h80);
        set_op(ALU_INC, 2'd2, 8'hFF, 1'b1, 8'h00, 2'd2, 1'b0);
        tick();
        check("inc ff r", r_q, 8'h00);
        check("inc ff flags", flags_q, 8'h02);

        // Sweep every op across operand sources, carries and writebacks
        tbl_a[0] = 8'hA5; tbl_a[1] = 8'h80;
        tbl_b[0] = 8'h3C; tbl_b[1] = 8'h80;
        for (int k = 0; k < 64; k++) begin
            set_op(alu_op_e'(4'(k % 16)), 2'(k % 4), tbl_b[(k / 16) % 2] ^ 8'h5A,
                   1'((k / 2) % 2), tbl_b[(k / 32) % 2], 2'((k / 3) % 4), 1'b0);
            data_in = tbl_a[(k / 16) % 2];
            p_c = 1'((k / 4) % 2);
            reg_write_en = 1'b1;
            reg_write_addr = 2'(k % 4);
            reg_read_addr_a = 2'((k + 1) % 4);
            reg_read_addr_b = 2'((k + 2) % 4);
            c_temp_en = 1'((k / 5) % 2);
            tick();
        end

        // Reset beats simultaneous write and c_temp load
        set_op(ALU_PASSB, 2'd2, 8'h55, 1'b1, 8'hAA, 2'd3, 1'b0);
        reg_write_en = 1'b1; c_temp_en = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; reg_write_en = 1'b0; c_temp_en = 1'b0;
        check("reset prio r_q", r_q, 8'h00);
        check("reset prio flags", flags_q, 8'h00);
        set_op(ALU_ADD, 2'd3, 8'h00, 1'b1, 8'h00, 2'd1, 1'b0);
        tick();
        check("c_temp cleared", r_q, 8'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
